// File: rtl/router_sync.sv
// rtl/router_sync.sv - destination latch and write-strobe steering for the 1x3 router
module router_sync (
   input  logic       clk1,
   input  logic       reset,
   input  logic       get_dest,
   input  logic       write_enb_reg,
   input  logic       empty_0,
   input  logic       empty_1,
   input  logic       empty_2,
   input  logic       full_0,
   input  logic       full_1,
   input  logic       full_2,
   input  logic [7:0] destination,
   output logic       vld_out_0,
   output logic       vld_out_1,
   output logic       vld_out_2,
   output logic [2:0] write_enb,
   output logic       fifo_full
);

   // 2'b11 is the "no destination" encoding; it selects no FIFO.
   localparam logic [1:0] ADDR_NONE = 2'b11;

   logic [1:0] addr;

   // Only the two address bits of the header byte matter.
   logic unused_dest_hi;
   assign unused_dest_hi = ^destination[7:2];

   // Destination register: reset clears the selection, get_dest captures a new one.
   always_ff @(posedge clk1) begin
      if (reset) begin
         addr <= ADDR_NONE;
      end else if (get_dest) begin
         addr <= destination[1:0];
      end
   end

   // Steer the write strobe and pick the selected full flag; both forced idle during reset.
   always_comb begin
      write_enb = 3'b000;
      fifo_full = 1'b0;
      if (!reset) begin
         case (addr)
            2'd0: begin
               write_enb = {2'b00, write_enb_reg};
               fifo_full = full_0;
            end
            2'd1: begin
               write_enb = {1'b0, write_enb_reg, 1'b0};
               fifo_full = full_1;
            end
            2'd2: begin
               write_enb = {write_enb_reg, 2'b00};
               fifo_full = full_2;
            end
            default: begin
               write_enb = 3'b000;
               fifo_full = 1'b0;
            end
         endcase
      end
   end

   // Port valid flags are simply the inverted FIFO empty flags, independent of selection.
   always_comb begin
      vld_out_0 = ~empty_0;
      vld_out_1 = ~empty_1;
      vld_out_2 = ~empty_2;
   end

endmodule

// File: tb/tb_router_sync.sv
// tb/tb_router_sync.sv - scoreboard bench for router_sync
module tb_router_sync;

   logic       clk1 = 1'b0;
   logic       reset = 1'b1;
   logic       get_dest = 1'b0;
   logic       write_enb_reg = 1'b0;
   logic       empty_0 = 1'b1, empty_1 = 1'b1, empty_2 = 1'b1;
   logic       full_0 = 1'b0, full_1 = 1'b0, full_2 = 1'b0;
   logic [7:0] destination = 8'h00;
   logic       vld_out_0, vld_out_1, vld_out_2;
   logic [2:0] write_enb;
   logic       fifo_full;

   router_sync dut (
      .clk1(clk1), .reset(reset), .get_dest(get_dest), .write_enb_reg(write_enb_reg),
      .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
      .full_0(full_0), .full_1(full_1), .full_2(full_2),
      .destination(destination),
      .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
      .write_enb(write_enb), .fifo_full(fifo_full)
   );

   always #5 clk1 = ~clk1;

   typedef struct packed {
      logic [2:0] we;
      logic       ff;
      logic [2:0] vld;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   sel = -1;   // selected port in the model, -1 = none
   int   step_no = 0;

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req, input int idx);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s step %0d: got %b, expected %b", name, idx, act, req);
      end
   endtask

   // One cycle of stimulus: drive inputs, queue the expected outputs, then advance the model at the edge.
   task automatic step(input logic r, input logic g, input logic w, input logic [7:0] d,
                       input logic [2:0] e, input logic [2:0] f);
      exp_t x;
      reset = r; get_dest = g; write_enb_reg = w; destination = d;
      empty_0 = e[0]; empty_1 = e[1]; empty_2 = e[2];
      full_0 = f[0]; full_1 = f[1]; full_2 = f[2];
      x.vld = ~e;
      x.we  = 3'b000;
      x.ff  = 1'b0;
      if (!r && sel >= 0) begin
         if (w) x.we = 3'(1 << sel);
         x.ff = f[sel];
      end
      q.push_back(x);
      @(posedge clk1);
      if (r) sel = -1;
      else if (g) sel = (d % 4 == 3) ? -1 : int'(d % 4);
      #1;
   endtask

   // Monitor: outputs are combinational, so each cycle's expectation is checked mid-cycle.
   always @(negedge clk1) begin
      if (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         step_no++;
         chk("write_enb", write_enb, x.we, step_no);
         chk("fifo_full", {2'b00, fifo_full}, {2'b00, x.ff}, step_no);
         chk("vld_out", {vld_out_2, vld_out_1, vld_out_0}, x.vld, step_no);
      end
   end

   initial begin
      @(posedge clk1);
      #1;
      // reset held with get_dest active
      step(1, 1, 1, 8'h01, 3'b110, 3'b111);
      step(1, 1, 1, 8'h01, 3'b110, 3'b111);
      // latch port 1
      step(0, 1, 1, 8'h05, 3'b000, 3'b000);
      step(0, 0, 1, 8'h05, 3'b000, 3'b010);
      step(0, 0, 1, 8'h05, 3'b010, 3'b101);
      // invalid address
      step(0, 1, 1, 8'h8F, 3'b110, 3'b111);
      step(0, 0, 1, 8'h8F, 3'b110, 3'b111);
      step(0, 0, 0, 8'h8F, 3'b110, 3'b111);
      // hold / overwrite
      step(0, 1, 1, 8'h00, 3'b000, 3'b001);
      step(0, 0, 1, 8'h02, 3'b000, 3'b001);
      step(0, 1, 1, 8'h02, 3'b000, 3'b000);
      step(0, 0, 1, 8'h02, 3'b000, 3'b100);
      // write gating on port 2
      step(0, 0, 1, 8'h02, 3'b001, 3'b000);
      step(0, 0, 0, 8'h02, 3'b001, 3'b000);
      step(0, 0, 1, 8'h02, 3'b001, 3'b000);
      // reset priority over get_dest
      step(1, 1, 1, 8'h00, 3'b000, 3'b111);
      step(0, 0, 1, 8'h00, 3'b000, 3'b111);
      // back-to-back captures, last wins
      step(0, 1, 1, 8'h01, 3'b000, 3'b000);
      step(0, 1, 1, 8'hFE, 3'b000, 3'b000);
      step(0, 0, 1, 8'h00, 3'b000, 3'b100);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
              8'($urandom), 3'($urandom), 3'($urandom));
      end
      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk1);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
